program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Byte-stream program loader and run controller for the piRISC core. Accepts a framed
//  image over a valid/ready byte link, writes it word-by-word into instruction memory,
//  holds the core in reset while loading, then raises go_contr. Watches the core's
//  instruction register for the halt word and reports done.
// PARAMETERS
//  ADDR_W       10            instruction-memory word-address width (capacity 2**ADDR_W words)
//  TIMEOUT_CYC  50000         max cycles between accepted bytes inside a frame before error
//  MAGIC        8'hA5         frame start byte
//  HALT_WORD    32'hFFFFFFFF  ir_in value that marks program end
// PORTS
//  clk           in   1         system clock, all logic on rising edge
//  reset         in   1         synchronous, active-high reset
//  rx_valid      in   1         byte source has rx_data available
//  rx_data       in   8         incoming byte
//  rx_ready      out  1         loader accepts byte this cycle (transfer = rx_valid & rx_ready)
//  imem_we       out  1         one-cycle instruction-memory write strobe
//  imem_addr     out  ADDR_W    word address of write
//  imem_wdata    out  32        write data
//  core_reset    out  1         drives core reset; 1 = core held in reset
//  go_contr      out  1         core run enable
//  ir_in         in   32        core irOut
//  busy          out  1         frame in progress (HDR_LO..CSUM)
//  done          out  1         program reached HALT_WORD
//  err           out  1         frame error or timeout
//  words_loaded  out  ADDR_W+1  words written in current/last frame
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. Reset: state IDLE, imem_we=0, imem_addr=0,
//    imem_wdata=0, core_reset=1, go_contr=0, busy=0, done=0, err=0, words_loaded=0, checksum=0.
//  - Frame: MAGIC, count_lo, count_hi (16-bit word count), count*4 data bytes (little-endian
//    per word), checksum byte = XOR of count_lo, count_hi and all data bytes.
//  - States: IDLE, HDR_LO, HDR_HI, DATA, CSUM, START, RUN, HALTED, ERROR.
//  - rx_ready = 1 in every state except START and RUN (combinational from state).
//  - IDLE/HALTED/ERROR: accepted MAGIC -> HDR_LO, clears done/err/words_loaded/checksum,
//    sets core_reset=1; any other accepted byte is discarded.
//  - HDR_HI: after byte, count > 2**ADDR_W -> ERROR; count==0 -> CSUM; else DATA.
//  - DATA: 4th accepted byte of a word -> next cycle imem_we=1 for exactly one cycle,
//    imem_addr=word index (0-based), imem_wdata={b3,b2,b1,b0}; words_loaded increments same
//    cycle. After last word's 4th byte -> CSUM. Back-to-back bytes every cycle supported.
//  - CSUM: byte == running XOR -> START; mismatch -> ERROR.
//  - START (1 cycle): core_reset -> 0. Next cycle RUN: go_contr=1, held high while in RUN.
//  - RUN: ir_in == HALT_WORD (sampled each clk) -> HALTED next cycle: go_contr=0,
//    core_reset=1, done=1. No timeout in RUN.
//  - ERROR: err=1, core_reset=1, go_contr=0; stays until reset or MAGIC.
//  - Timeout: in HDR_LO..CSUM, idle counter resets on each accepted byte; reaching
//    TIMEOUT_CYC -> ERROR. Counter saturates, held 0 outside a frame.
//  - Simultaneous: timeout expiry and byte acceptance in same cycle -> byte wins.
//  - Reset mid-frame: frame aborted, partially assembled word dropped, no imem_we issued.
// STRUCTURE
//  - Shared header loader_defs.vh: state encodings, frame field widths, default MAGIC and
//    HALT_WORD constants.
//  - One sub-module word_packer: shifts 4 bytes into a 32-bit word, byte index counter,
//    emits word_valid pulse; cleared by top-level on reset/new frame.
//  - Top-level holds FSM, checksum register, word-count/address counters, timeout counter.
// TESTING
//  1. MAGIC,02,00,13,00,00,00,FF,FF,FF,FF,11 -> imem writes [0]=00000013,[1]=FFFFFFFF;
//     core_reset falls in START, go_contr=1 next cycle; drive ir_in=FFFFFFFF -> done=1, go_contr=0.
//  2. Same frame with checksum 12 -> err=1, no START, core_reset stays 1, go_contr stays 0.
//  3. ADDR_W=10, count=0x0401 -> err=1 right after count_hi, zero imem_we pulses.
//  4. MAGIC,01,00,AA then stall TIMEOUT_CYC cycles -> err=1; then valid frame -> loads, err clears.
//  5. reset asserted mid-DATA (after 6 data bytes) -> next cycle IDLE, busy=0, words_loaded=0,
//     no imem_we; subsequent full frame loads correctly.
//  6. Non-MAGIC bytes in IDLE, rx_valid gaps, and bytes offered during RUN -> ignored /
//     rx_ready=0 in RUN; image and timing unaffected.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package program_loader_pkg;

  localparam int unsigned ByteW  = 8;
  localparam int unsigned WordW  = 32;
  localparam int unsigned CountW = 16;

  localparam logic [ByteW-1:0] MagicDefault    = 8'hA5;
  localparam logic [WordW-1:0] HaltWordDefault = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    StIdle,
    StHdrLo,
    StHdrHi,
    StData,
    StCsum,
    StStart,
    StRun,
    StHalted,
    StError
  } state_e;

  // True while a frame is being received (header through checksum).
  function automatic logic in_frame(state_e s);
    return s inside {StHdrLo, StHdrHi, StData, StCsum};
  endfunction

endpackage

// File: rtl/program_loader_word_packer.sv
// Assembles four little-endian bytes into a 32-bit word and pulses word_valid_o
// for one cycle after the fourth byte.
module program_loader_word_packer
  import program_loader_pkg::*;
(
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             byte_valid_i,
  input  logic [ByteW-1:0] byte_i,
  output logic             last_byte_o,
  output logic             word_valid_o,
  output logic [WordW-1:0] word_o
);

  logic [1:0]       idx_q, idx_d;
  logic [23:0]      shift_q, shift_d;
  logic [WordW-1:0] word_q, word_d;
  logic             valid_q, valid_d;

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (byte_valid_i) begin
      if (idx_q == 2'd3) begin
        word_d  = {byte_i, shift_q};
        valid_d = 1'b1;
        idx_d   = 2'd0;
      end else begin
        shift_d = {byte_i, shift_q[23:8]};
        idx_d   = idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      idx_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign last_byte_o  = (idx_q == 2'd3);
  assign word_valid_o = valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/program_loader.sv
// Frame receiver, instruction-memory writer and core run controller for piRISC.
// Core is held in reset except in StStart/StRun; done/err are decoded from state.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned      ADDR_W      = 10,
  parameter int unsigned      TIMEOUT_CYC = 50000,
  parameter logic [ByteW-1:0] MAGIC       = MagicDefault,
  parameter logic [WordW-1:0] HALT_WORD   = HaltWordDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [ByteW-1:0]  rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WordW-1:0]  imem_wdata,
  output logic              core_reset,
  output logic              go_contr,
  input  logic [WordW-1:0]  ir_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned     TmoW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmoW-1:0] TmoLimit = TmoW'(TIMEOUT_CYC);
  localparam logic [CountW:0] MaxWords = (CountW + 1)'(2 ** ADDR_W);

  state_e              state_q, state_d;
  logic [ByteW-1:0]    cnt_lo_q, cnt_lo_d;
  logic [CountW-1:0]   count_q, count_d;
  logic [ByteW-1:0]    csum_q, csum_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  logic              xfer, magic_hit, pk_last, pk_valid;
  logic [WordW-1:0]  pk_word;
  logic [CountW-1:0] hdr_count;
  logic [ADDR_W:0]   words_nxt;

  assign rx_ready  = !(state_q inside {StStart, StRun});
  assign xfer      = rx_valid && rx_ready;
  assign magic_hit = xfer && (rx_data == MAGIC) && (state_q inside {StIdle, StHalted, StError});
  assign hdr_count = {rx_data, cnt_lo_q};
  assign words_nxt = words_q + 1'b1;

  program_loader_word_packer u_packer (
    .clk_i        (clk),
    .clear_i      (reset || magic_hit),
    .byte_valid_i (xfer && (state_q == StData)),
    .byte_i       (rx_data),
    .last_byte_o  (pk_last),
    .word_valid_o (pk_valid),
    .word_o       (pk_word)
  );

  always_comb begin
    state_d  = state_q;
    cnt_lo_d = cnt_lo_q;
    count_d  = count_q;
    csum_d   = csum_q;
    words_d  = words_q;
    addr_d   = addr_q;
    tmo_d    = '0;

    if (in_frame(state_q) && !xfer && (tmo_q != TmoLimit)) begin
      tmo_d = tmo_q + 1'b1;
    end

    unique case (state_q)
      StIdle, StHalted, StError: begin
        if (magic_hit) begin
          state_d = StHdrLo;
          csum_d  = '0;
          words_d = '0;
        end
      end
      StHdrLo: begin
        if (xfer) begin
          cnt_lo_d = rx_data;
          csum_d   = csum_q ^ rx_data;
          state_d  = StHdrHi;
        end
      end
      StHdrHi: begin
        if (xfer) begin
          count_d = hdr_count;
          csum_d  = csum_q ^ rx_data;
          if ({1'b0, hdr_count} > MaxWords) begin
            state_d = StError;
          end else if (hdr_count == '0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          csum_d = csum_q ^ rx_data;
          if (pk_last) begin
            words_d = words_nxt;
            addr_d  = words_q[ADDR_W-1:0];
            if (CountW'(words_nxt) == count_q) begin
              state_d = StCsum;
            end
          end
        end
      end
      StCsum: begin
        if (xfer) begin
          state_d = (rx_data == csum_q) ? StStart : StError;
        end
      end
      StStart: state_d = StRun;
      StRun: begin
        if (ir_in == HALT_WORD) begin
          state_d = StHalted;
        end
      end
      default: state_d = StIdle;
    endcase

    // An accepted byte always beats an expiring timeout.
    if (in_frame(state_q) && !xfer && (tmo_d == TmoLimit)) begin
      state_d = StError;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_lo_q <= '0;
      count_q  <= '0;
      csum_q   <= '0;
      tmo_q    <= '0;
      words_q  <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_lo_q <= cnt_lo_d;
      count_q  <= count_d;
      csum_q   <= csum_d;
      tmo_q    <= tmo_d;
      words_q  <= words_d;
      addr_q   <= addr_d;
    end
  end

  assign imem_we      = pk_valid;
  assign imem_addr    = addr_q;
  assign imem_wdata   = pk_word;
  assign core_reset   = !(state_q inside {StStart, StRun});
  assign go_contr     = (state_q == StRun);
  assign busy         = in_frame(state_q);
  assign done         = (state_q == StHalted);
  assign err          = (state_q == StError);
  assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: scoreboarded imem writes plus control-flow checks.
module tb_program_loader;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned TB_TMO = 300;
  localparam logic [7:0]  MAGIC_B = 8'hA5;
  localparam logic [31:0] HALT_W  = 32'hFFFF_FFFF;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              go_contr;
  logic [31:0]       ir_in;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         sb_q[$];
  logic [31:0] img [0:7];
  int          n_checks = 0;
  int          n_errors = 0;

  program_loader #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TB_TMO),
    .MAGIC       (MAGIC_B),
    .HALT_WORD   (HALT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_reset   (core_reset),
    .go_contr     (go_contr),
    .ir_in        (ir_in),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_we", {54'd0, imem_addr}, 64'hDEAD);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("we_addr", {54'd0, imem_addr}, {54'd0, e.addr});
        check("we_data", {32'd0, imem_wdata}, {32'd0, e.data});
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard    = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("ready_wait", 64'd0, 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] csum_flip, input bit gaps);
    logic [15:0] c16;
    logic [7:0]  cs;
    logic [7:0]  b;
    wr_t         e;
    c16 = 16'(n);
    cs  = c16[7:0] ^ c16[15:8];
    send_byte(MAGIC_B);
    send_byte(c16[7:0]);
    send_byte(c16[15:8]);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        b  = img[i][8*j +: 8];
        cs = cs ^ b;
        if (j == 3) begin
          e.addr = ADDR_W'(i);
          e.data = img[i];
          sb_q.push_back(e);
        end
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        send_byte(b);
      end
    end
    send_byte(cs ^ csum_flip);
  endtask

  // Entered in the StStart cycle; offers bytes during RUN, then halts the core.
  task automatic run_and_halt(input int exp_words);
    check("start_core_reset", {63'd0, core_reset}, 64'd0);
    check("start_go", {63'd0, go_contr}, 64'd0);
    rx_valid = 1'b1;
    rx_data  = MAGIC_B;
    ir_in    = 32'hFFFF_FFFE;
    @(negedge clk);
    check("run_go", {63'd0, go_contr}, 64'd1);
    check("run_ready", {63'd0, rx_ready}, 64'd0);
    repeat (3) begin
      ir_in = $urandom() & 32'h7FFF_FFFF;
      @(negedge clk);
      check("run_hold_go", {63'd0, go_contr}, 64'd1);
    end
    rx_valid = 1'b0;
    ir_in    = HALT_W;
    @(negedge clk);
    check("halt_done", {63'd0, done}, 64'd1);
    check("halt_go", {63'd0, go_contr}, 64'd0);
    check("halt_core_reset", {63'd0, core_reset}, 64'd1);
    check("halt_words", {53'd0, words_loaded}, 64'(exp_words));
    check("halt_sb_empty", 64'(sb_q.size()), 64'd0);
    ir_in = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wr_t e;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    ir_in    = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_core_reset", {63'd0, core_reset}, 64'd1);
    check("rst_go", {63'd0, go_contr}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_words", {53'd0, words_loaded}, 64'd0);
    check("rst_addr_data", {22'd0, imem_addr, imem_wdata}, 64'd0);
    check("rst_we", {63'd0, imem_we}, 64'd0);
    check("rst_ready", {63'd0, rx_ready}, 64'd1);
    reset = 1'b0;
    @(negedge clk);

    // Junk bytes in idle are dropped.
    send_byte(8'h00);
    send_byte(8'h5A);
    send_byte(8'hA4);
    check("idle_junk_busy", {63'd0, busy}, 64'd0);

    // Basic two-word frame, then run and halt.
    img[0] = 32'h0000_0013;
    img[1] = 32'hFFFF_FFFF;
    send_frame(2, 8'h00, 1'b0);
    run_and_halt(2);

    // Bad checksum: data written, but core never released.
    send_frame(2, 8'h03, 1'b0);
    check("csum_err", {63'd0, err}, 64'd1);
    check("csum_core_reset", {63'd0, core_reset}, 64'd1);
    check("csum_go", {63'd0, go_contr}, 64'd0);
    @(negedge clk);
    check("csum_err_hold", {63'd0, err}, 64'd1);
    check("csum_go_hold", {63'd0, go_contr}, 64'd0);

    // Oversize count rejected right after count_hi.
    send_byte(MAGIC_B);
    check("magic_clears_err", {63'd0, err}, 64'd0);
    send_byte(8'h01);
    send_byte(8'h04);
    check("oversize_err", {63'd0, err}, 64'd1);
    check("oversize_busy", {63'd0, busy}, 64'd0);
    // Exactly capacity is accepted.
    send_byte(MAGIC_B);
    send_byte(8'h00);
    send_byte(8'h04);
    check("maxcount_busy", {63'd0, busy}, 64'd1);
    check("maxcount_err", {63'd0, err}, 64'd0);

    // Reset mid-DATA after 6 data bytes: first word lands, second is dropped.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    img[0] = 32'h1122_3344;
    img[1] = 32'h5566_7788;
    send_byte(MAGIC_B);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int k = 0; k < 6; k++) begin
      if (k == 3) begin
        e.addr = '0;
        e.data = img[0];
        sb_q.push_back(e);
      end
      send_byte(img[k / 4][8*(k % 4) +: 8]);
    end
    check("mid_words", {53'd0, words_loaded}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_busy", {63'd0, busy}, 64'd0);
    check("mrst_words", {53'd0, words_loaded}, 64'd0);
    check("mrst_we", {63'd0, imem_we}, 64'd0);
    repeat (4) @(negedge clk);

    // Full frame with rx_valid gaps after the aborted one.
    img[0] = 32'hDEAD_BEEF;
    img[1] = 32'h0BAD_F00D;
    img[2] = 32'h0000_0001;
    send_frame(3, 8'h00, 1'b1);
    run_and_halt(3);

    // Timeout: stall inside DATA.
    send_byte(MAGIC_B);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    repeat (TB_TMO - 1) @(negedge clk);
    check("tmo_not_yet", {63'd0, err}, 64'd0);
    check("tmo_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check("tmo_err", {63'd0, err}, 64'd1);
    check("tmo_busy_clr", {63'd0, busy}, 64'd0);
    img[0] = 32'hCAFE_F00D;
    send_frame(1, 8'h00, 1'b0);
    check("tmo_recover_err", {63'd0, err}, 64'd0);
    run_and_halt(1);

    // Empty program goes straight to the checksum.
    send_frame(0, 8'h00, 1'b0);
    run_and_halt(0);

    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
